hitspy6_tx: RTL and testbench

Transmit-side counterpart of the six-layer hit demultiplexer. Accepts one event's worth of per-layer hits (five 8-bit SVX hits, one 13-bit XFT hit) plus a 5-bit hitmap in parallel, and serialises them onto the 15-bit HITIN/DV/HITMAP word stream consumed by the receiver. Sits upstream of the receiver as the test-pattern and forwarding source. Supports downstream back-pressure.

---
 rtl/hitspy6_tx_if.sv | 31 +++
 rtl/hitspy6_tx.sv | 148 ++++++++++++++
 tb/tb_hitspy6_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hitspy6_tx_if.sv
// Bus bundle for hitspy6_tx: parallel per-event hit load on one side, serial
// HITIN/DV/HITMAP word stream with back-pressure on the other.
interface hitspy6_tx_if #(
    parameter int unsigned HITBITS_SVX = 8,
    parameter int unsigned HITBITS_XFT = 13
);
    logic                   load;
    logic [4:0]             hitmap_in;
    logic [HITBITS_SVX-1:0] hits1;
    logic [HITBITS_SVX-1:0] hits2;
    logic [HITBITS_SVX-1:0] hits3;
    logic [HITBITS_SVX-1:0] hits4;
    logic [HITBITS_SVX-1:0] hits5;
    logic [HITBITS_XFT-1:0] hits6;
    logic                   hold;
    logic                   ready_c;
    logic [14:0]            hitout;
    logic [4:0]             hitmap;
    logic                   dv;
    logic [HITBITS_XFT-9:0] xft_phi_msb;

    modport master (
        output load, hitmap_in, hits1, hits2, hits3, hits4, hits5, hits6, hold,
        input  ready_c, hitout, hitmap, dv, xft_phi_msb
    );

    modport slave (
        input  load, hitmap_in, hits1, hits2, hits3, hits4, hits5, hits6, hold,
        output ready_c, hitout, hitmap, dv, xft_phi_msb
    );
endinterface

// File: rtl/hitspy6_tx.sv
// Six-layer hit serialiser: captures one event in parallel and emits layer 1..6 words.
// Define HITSPY6_TX_SKIP_EN to skip layers 1-5 whose hitmap bit is clear.
module hitspy6_tx #(
    parameter int unsigned HITBITS_SVX = 8,
    parameter int unsigned HITBITS_XFT = 13
) (
    input logic         clk,
    input logic         rst_n,
    hitspy6_tx_if.slave tx_if
);
    localparam int unsigned NSVX   = 5;
    localparam int unsigned WORD_W = 15;
    localparam int unsigned MSB_W  = HITBITS_XFT - 8;
    localparam logic [2:0]  SEL_L6 = 3'd5;
    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_SEND = 1'b1;
`ifdef HITSPY6_TX_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    typedef logic [NSVX-1:0][HITBITS_SVX-1:0] svx_t;

    // Lowest layer at or above start that is sent; layer 6 when none remain.
    function automatic logic [2:0] scan_sel(input logic [2:0] start, input logic [NSVX-1:0] map);
        logic [2:0] sel;
        sel = SEL_L6;
        for (int i = int'(NSVX) - 1; i >= 0; i--) begin
            if (3'(i) >= start && (map[3'(i)] || !SKIP_EN)) sel = 3'(i);
        end
        return sel;
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input logic [2:0] sel, input svx_t svx,
                                                  input logic [HITBITS_XFT-1:0] xft,
                                                  input logic [NSVX-1:0] map);
        logic [WORD_W-1:0] w;
        w = '0;
        if (sel == SEL_L6)  w = {1'b1, 4'b0000, xft[7:0], 2'b00};
        else if (map[sel])  w = WORD_W'(svx[sel]);
        return w;
    endfunction

    function automatic logic [MSB_W-1:0] msb_of(input logic [2:0] sel, input logic [HITBITS_XFT-1:0] xft);
        return (sel == SEL_L6) ? xft[HITBITS_XFT-1:8] : '0;
    endfunction

    logic [0:0]             state_q, state_d;
    logic [2:0]             ptr_q, ptr_d;
    svx_t                   svx_q, svx_d;
    logic [HITBITS_XFT-1:0] xft_q, xft_d;
    logic [NSVX-1:0]        map_q, map_d;
    logic                   dv_q, dv_d;
    logic [WORD_W-1:0]      hitout_q, hitout_d;
    logic [NSVX-1:0]        hitmap_q, hitmap_d;
    logic [MSB_W-1:0]       msb_q, msb_d;

    svx_t       in_svx;
    logic [2:0] first_sel;
    logic       last_out;

    assign in_svx   = {tx_if.hits5, tx_if.hits4, tx_if.hits3, tx_if.hits2, tx_if.hits1};
    assign last_out = dv_q & hitout_q[WORD_W-1];

    assign tx_if.ready_c     = (state_q == S_IDLE) | (last_out & ~tx_if.hold);
    assign tx_if.dv          = dv_q;
    assign tx_if.hitout      = hitout_q;
    assign tx_if.hitmap      = hitmap_q;
    assign tx_if.xft_phi_msb = msb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            svx_q    <= '0;
            xft_q    <= '0;
            map_q    <= '0;
            dv_q     <= 1'b0;
            hitout_q <= '0;
            hitmap_q <= '0;
            msb_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            svx_q    <= svx_d;
            xft_q    <= xft_d;
            map_q    <= map_d;
            dv_q     <= dv_d;
            hitout_q <= hitout_d;
            hitmap_q <= hitmap_d;
            msb_q    <= msb_d;
        end
    end

    // An accept while the end-of-event word is out forwards the new first word
    // straight from the inputs so consecutive events have no DV gap.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        svx_d     = svx_q;
        xft_d     = xft_q;
        map_d     = map_q;
        dv_d      = dv_q;
        hitout_d  = hitout_q;
        hitmap_d  = hitmap_q;
        msb_d     = msb_q;
        first_sel = scan_sel(3'd0, tx_if.hitmap_in);
        case (state_q)
            S_IDLE: begin
                if (tx_if.load) begin
                    svx_d   = in_svx;
                    xft_d   = tx_if.hits6;
                    map_d   = tx_if.hitmap_in;
                    ptr_d   = first_sel;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_if.hold) begin
                    if (last_out && tx_if.load) begin
                        svx_d    = in_svx;
                        xft_d    = tx_if.hits6;
                        map_d    = tx_if.hitmap_in;
                        dv_d     = 1'b1;
                        hitout_d = word_of(first_sel, in_svx, tx_if.hits6, tx_if.hitmap_in);
                        hitmap_d = tx_if.hitmap_in;
                        msb_d    = msb_of(first_sel, tx_if.hits6);
                        ptr_d    = scan_sel(first_sel + 3'd1, tx_if.hitmap_in);
                    end else if (last_out) begin
                        state_d  = S_IDLE;
                        dv_d     = 1'b0;
                        hitout_d = '0;
                        hitmap_d = '0;
                        msb_d    = '0;
                    end else begin
                        dv_d     = 1'b1;
                        hitout_d = word_of(ptr_q, svx_q, xft_q, map_q);
                        hitmap_d = map_q;
                        msb_d    = msb_of(ptr_q, xft_q);
                        ptr_d    = scan_sel(ptr_q + 3'd1, map_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_hitspy6_tx.sv
// Self-checking bench for hitspy6_tx: vector table plus stall, back-to-back and reset sequences.
// Build with or without HITSPY6_TX_SKIP_EN; expectations follow the same macro.
module tb_hitspy6_tx;
    localparam int unsigned SVX_W = 8;
    localparam int unsigned XFT_W = 13;
    localparam int unsigned MSB_W = XFT_W - 8;

    typedef struct packed {
        logic [14:0]      hitout;
        logic [4:0]       hitmap;
        logic [MSB_W-1:0] msb;
    } exp_t;

    typedef struct {
        logic [4:0]       map;
        logic [4:0][7:0]  svx;
        logic [12:0]      h6;
        int               len_skip;
        int               len_full;
        logic [14:0]      eoe;
        logic [4:0]       msb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   dv_total = 0;
    exp_t sb[$];
    exp_t cur;
    logic [14:0] eoe_word;
    logic [4:0]  eoe_msb;
    vec_t vecs[5];

    hitspy6_tx_if #(.HITBITS_SVX(SVX_W), .HITBITS_XFT(XFT_W)) tx ();

    hitspy6_tx #(.HITBITS_SVX(SVX_W), .HITBITS_XFT(XFT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tx.dv === 1'b1) dv_total++;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void push_event(input logic [4:0] map, input logic [4:0][7:0] svx, input logic [12:0] h6);
        exp_t e;
        logic [2:0] idx;
        for (int k = 0; k < 5; k++) begin
            idx = 3'(k);
`ifdef HITSPY6_TX_SKIP_EN
            if (!map[idx]) continue;
`endif
            e.hitout = map[idx] ? {7'd0, svx[idx]} : 15'd0;
            e.hitmap = map;
            e.msb    = '0;
            sb.push_back(e);
        end
        e.hitout = {1'b1, 4'd0, h6[7:0], 2'b00};
        e.hitmap = map;
        e.msb    = h6[12:8];
        sb.push_back(e);
    endfunction

    function automatic int exp_len(input vec_t v);
`ifdef HITSPY6_TX_SKIP_EN
        return v.len_skip;
`else
        return v.len_full;
`endif
    endfunction

    // Scoreboard: a word advanced through a non-HOLD edge is popped, a held word must repeat.
    initial begin : monitor
        logic h;
        forever begin
            @(posedge clk);
            h = tx.hold;
            @(negedge clk);
            if (rst_n === 1'b1 && tx.dv === 1'b1) begin
                if (!h) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected none", tx.hitout);
                    end else begin
                        cur = sb.pop_front();
                        if (tx.hitout[14] === 1'b1) begin
                            eoe_word = tx.hitout;
                            eoe_msb  = tx.xft_phi_msb;
                        end
                    end
                end
                chk("word_hitout", 32'(tx.hitout), 32'(cur.hitout));
                chk("word_hitmap", 32'(tx.hitmap), 32'(cur.hitmap));
                chk("word_msb", 32'(tx.xft_phi_msb), 32'(cur.msb));
            end
        end
    end

    task automatic apply(input vec_t v, input bit accept);
        tx.hitmap_in = v.map;
        tx.hits1 = v.svx[0];
        tx.hits2 = v.svx[1];
        tx.hits3 = v.svx[2];
        tx.hits4 = v.svx[3];
        tx.hits5 = v.svx[4];
        tx.hits6 = v.h6;
        tx.load  = 1'b1;
        chk("ready_at_load", 32'(tx.ready_c), 32'(accept));
        if (accept) push_event(v.map, v.svx, v.h6);
        @(negedge clk);
        tx.load      = 1'b0;
        tx.hitmap_in = 5'($urandom);
        tx.hits1     = 8'($urandom);
        tx.hits2     = 8'($urandom);
        tx.hits3     = 8'($urandom);
        tx.hits4     = 8'($urandom);
        tx.hits5     = 8'($urandom);
        tx.hits6     = 13'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (tx.dv === 1'b1) begin
                seen = 1'b1;
                if (tx.hitout[14] === 1'b1 && tx.hold === 1'b0)
                    chk("ready_on_eoe", 32'(tx.ready_c), 32'd1);
            end else if (seen) begin
                done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: got no end of event expected DV to drop", name);
        end
    endtask

    task automatic wait_word(input logic [14:0] w, input string name);
        int n = 0;
        while (!(tx.dv === 1'b1 && tx.hitout === w) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout expected word %0h", name, w);
        end
    endtask

    initial begin : main
        int base;
        vecs[0] = '{5'b11111, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 13'h1ABC, 6, 6, 15'h42F0, 5'h1A};
        vecs[1] = '{5'b10101, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 13'h1ABC, 4, 6, 15'h42F0, 5'h1A};
        vecs[2] = '{5'b00000, {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1}, 13'h0123, 1, 6, 15'h408C, 5'h01};
        vecs[3] = '{5'b01010, {8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1}, 13'h1FFF, 3, 6, 15'h43FC, 5'h1F};
        vecs[4] = '{5'b10000, {8'h77, 8'h66, 8'h55, 8'h44, 8'h33}, 13'h0000, 2, 6, 15'h4000, 5'h00};

        rst_n = 1'b0;
        tx.load = 1'b0;
        tx.hold = 1'b0;
        tx.hitmap_in = '0;
        tx.hits1 = '0;
        tx.hits2 = '0;
        tx.hits3 = '0;
        tx.hits4 = '0;
        tx.hits5 = '0;
        tx.hits6 = '0;
        repeat (2) @(negedge clk);
        chk("rst_dv", 32'(tx.dv), 32'd0);
        chk("rst_hitout", 32'(tx.hitout), 32'd0);
        chk("rst_hitmap", 32'(tx.hitmap), 32'd0);
        chk("rst_msb", 32'(tx.xft_phi_msb), 32'd0);
        chk("rst_ready", 32'(tx.ready_c), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            base = dv_total;
            apply(vecs[i], 1'b1);
            chk($sformatf("vec%0d_latency_dv", i), 32'(tx.dv), 32'd0);
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_len", i), 32'(dv_total - base), 32'(exp_len(vecs[i])));
            chk($sformatf("vec%0d_eoe", i), 32'(eoe_word), 32'(vecs[i].eoe));
            chk($sformatf("vec%0d_msb", i), 32'(eoe_msb), 32'(vecs[i].msb));
            chk($sformatf("vec%0d_sb_empty", i), 32'(sb.size()), 32'd0);
            chk($sformatf("vec%0d_idle_hitout", i), 32'(tx.hitout), 32'd0);
            @(negedge clk);
        end

        // Stall three cycles on the layer-3 word.
        base = dv_total;
        apply(vecs[0], 1'b1);
        wait_word(15'h0033, "hold_l3");
        tx.hold = 1'b1;
        chk("hold_ready", 32'(tx.ready_c), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("hold_word", 32'(tx.hitout), 32'h33);
            chk("hold_ready", 32'(tx.ready_c), 32'd0);
        end
        tx.hold = 1'b0;
        wait_done("hold");
        chk("hold_len", 32'(dv_total - base), 32'd9);
        chk("hold_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);

        // Back-to-back events with an ignored mid-event load.
        base = dv_total;
        apply(vecs[0], 1'b1);
        wait_word(15'h0022, "b2b_l2");
        apply(vecs[2], 1'b0);
        wait_word(15'h42F0, "b2b_eoe");
        apply(vecs[1], 1'b1);
        chk("b2b_no_gap", 32'(tx.dv), 32'd1);
        wait_done("b2b");
        chk("b2b_len", 32'(dv_total - base), 32'(6 + exp_len(vecs[1])));
        chk("b2b_eoe", 32'(eoe_word), 32'(vecs[1].eoe));
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);

        // Reset during the layer-2 word.
        apply(vecs[0], 1'b1);
        wait_word(15'h0022, "rst_l2");
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_dv", 32'(tx.dv), 32'd0);
        chk("midrst_hitout", 32'(tx.hitout), 32'd0);
        chk("midrst_hitmap", 32'(tx.hitmap), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("postrst_ready", 32'(tx.ready_c), 32'd1);
        base = dv_total;
        repeat (5) @(negedge clk);
        chk("postrst_no_words", 32'(dv_total - base), 32'd0);
        chk("postrst_hitout", 32'(tx.hitout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
